sram_arbiter: RTL and testbench

Shares the single external 512 KB SRAM (19-bit address, 8-bit data, active-low write enable) between three requesters: the ULA video fetch port (read-only), the Z80 memory port, and a bulk loader port used by the boot firmware to copy ROM images from SPI flash. It sits between the memory-mapping logic and the SRAM pins and owns the `sram_addr`, `sram_data` and `sram_we_n` pins. It sequences every access as a fixed-length read or write cycle. It arbitrates with video first, then CPU over loader, and a starvation guard keeps the loader from waiting forever.

---
 rtl/sram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Three-port arbiter for the shared 512 KB async SRAM: video reads, CPU and
// bulk-loader read/write, sequenced as fixed-length read and write cycles.
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        vreq,
    input  logic [18:0] vaddr,
    output logic        vack,
    output logic [7:0]  vdata,

    input  logic        creq,
    input  logic        cwe,
    input  logic [18:0] caddr,
    input  logic [7:0]  cdin,
    output logic        cack,
    output logic [7:0]  cdout,

    input  logic        lreq,
    input  logic        lwe,
    input  logic [18:0] laddr,
    input  logic [7:0]  ldin,
    output logic        lack,
    output logic [7:0]  ldout,

    output logic [18:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_we_n
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2,
        WR3
    } state_t;

    typedef enum logic [1:0] {
        OWN_V,
        OWN_C,
        OWN_L
    } owner_t;

    state_t          state;
    owner_t          owner;
    logic [DW-1:0]   wdata;
    logic            drive_en;
    logic [CW-1:0]   starve_cnt;

    logic            starve_hit;
    logic            grant_v;
    logic            grant_c;
    logic            grant_l;

    // Bus is driven only from the registered enable, i.e. WR1..WR3.
    assign sram_data = drive_en ? wdata : {DW{1'bz}};

    // Arbitration: the port being acked this cycle is masked; the loader is
    // held off by a raw CPU request unless the starvation limit is reached.
    always_comb begin
        starve_hit = 1'b0;
        grant_v    = 1'b0;
        grant_c    = 1'b0;
        grant_l    = 1'b0;
        starve_hit = (starve_cnt == CW'(STARVE_LIMIT));
        grant_v    = vreq && !vack;
        grant_l    = !grant_v && lreq && !lack && (starve_hit || !creq);
        grant_c    = !grant_v && !grant_l && creq && !cack;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_V;
            wdata      <= '0;
            drive_en   <= 1'b0;
            starve_cnt <= '0;
            sram_addr  <= '0;
            sram_we_n  <= 1'b1;
            vack       <= 1'b0;
            cack       <= 1'b0;
            lack       <= 1'b0;
            vdata      <= '0;
            cdout      <= '0;
            ldout      <= '0;
        end else begin
            vack <= 1'b0;
            cack <= 1'b0;
            lack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_v) begin
                        owner     <= OWN_V;
                        sram_addr <= vaddr;
                        state     <= RD1;
                    end else if (grant_c) begin
                        owner     <= OWN_C;
                        sram_addr <= caddr;
                        wdata     <= cdin;
                        if (cwe) begin
                            drive_en <= 1'b1;
                            state    <= WR1;
                        end else begin
                            state    <= RD1;
                        end
                        if (lreq && (starve_cnt < CW'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else if (grant_l) begin
                        owner      <= OWN_L;
                        sram_addr  <= laddr;
                        wdata      <= ldin;
                        starve_cnt <= '0;
                        if (lwe) begin
                            drive_en <= 1'b1;
                            state    <= WR1;
                        end else begin
                            state    <= RD1;
                        end
                    end
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    case (owner)
                        OWN_V: begin
                            vdata <= sram_data;
                            vack  <= 1'b1;
                        end
                        OWN_C: begin
                            cdout <= sram_data;
                            cack  <= 1'b1;
                        end
                        OWN_L: begin
                            ldout <= sram_data;
                            lack  <= 1'b1;
                        end
                        default: ;
                    endcase
                    state <= IDLE;
                end
                WR1: begin
                    sram_we_n <= 1'b0;
                    state     <= WR2;
                end
                WR2: begin
                    sram_we_n <= 1'b1;
                    state     <= WR3;
                end
                WR3: begin
                    drive_en <= 1'b0;
                    case (owner)
                        OWN_C:   cack <= 1'b1;
                        OWN_L:   lack <= 1'b1;
                        default: ;
                    endcase
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model on the shared bus.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        vreq;
    logic [18:0] vaddr;
    logic        vack;
    logic [7:0]  vdata;
    logic        creq;
    logic        cwe;
    logic [18:0] caddr;
    logic [7:0]  cdin;
    logic        cack;
    logic [7:0]  cdout;
    logic        lreq;
    logic        lwe;
    logic [18:0] laddr;
    logic [7:0]  ldin;
    logic        lack;
    logic [7:0]  ldout;
    logic [18:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_we_n;

    logic        model_oe;
    logic [7:0]  mem [0:4095];

    int checks;
    int failures;

    sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .vreq      (vreq),
        .vaddr     (vaddr),
        .vack      (vack),
        .vdata     (vdata),
        .creq      (creq),
        .cwe       (cwe),
        .caddr     (caddr),
        .cdin      (cdin),
        .cack      (cack),
        .cdout     (cdout),
        .lreq      (lreq),
        .lwe       (lwe),
        .laddr     (laddr),
        .ldin      (ldin),
        .lack      (lack),
        .ldout     (ldout),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: 4 KB alias of the address space, drives only when enabled.
    assign sram_data = model_oe ? mem[sram_addr[11:0]] : 8'hzz;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h345] = 8'hA5;
        mem[12'h200] = 8'h11;
        mem[12'h300] = 8'h22;
        mem[12'h400] = 8'h33;
        forever begin
            @(posedge clk);
            if (!sram_we_n) mem[sram_addr[11:0]] = sram_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        model_oe = 1'b0;
        vreq = 0; vaddr = '0;
        creq = 0; cwe = 0; caddr = '0; cdin = '0;
        lreq = 0; lwe = 0; laddr = '0; ldin = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_addr",   32'(sram_addr), 32'h0);
        check("rst_we_n",   32'(sram_we_n), 32'h1);
        check("rst_drive",  32'(dut.drive_en), 32'h0);
        check("rst_acks",   32'({vack, cack, lack}), 32'h0);
        check("rst_douts",  32'({vdata, cdout, ldout}), 32'h0);
        check("rst_starve", 32'(dut.starve_cnt), 32'h0);

        // Single CPU read
        model_oe = 1'b1;
        creq = 1; cwe = 0; caddr = 19'h12345;
        tick();
        check("rd_rd1_ack",  32'(cack), 32'h0);
        check("rd_rd1_addr", 32'(sram_addr), 32'h12345);
        check("rd_rd1_we",   32'(sram_we_n), 32'h1);
        check("rd_rd1_drv",  32'(dut.drive_en), 32'h0);
        tick();
        check("rd_rd2_ack",  32'(cack), 32'h0);
        check("rd_rd2_drv",  32'(dut.drive_en), 32'h0);
        tick();
        check("rd_ack",      32'(cack), 32'h1);
        check("rd_data",     32'(cdout), 32'hA5);
        creq = 0;
        tick();
        check("rd_ack_off",  32'(cack), 32'h0);
        check("rd_data_hold", 32'(cdout), 32'hA5);

        // CPU write with data changed after grant
        model_oe = 1'b0;
        creq = 1; cwe = 1; caddr = 19'h00100; cdin = 8'h3C;
        tick();
        cdin = 8'hFF; caddr = 19'h00777;
        check("wr1_we",   32'(sram_we_n), 32'h1);
        check("wr1_drv",  32'(dut.drive_en), 32'h1);
        check("wr1_data", 32'(sram_data), 32'h3C);
        check("wr1_addr", 32'(sram_addr), 32'h00100);
        tick();
        check("wr2_we",   32'(sram_we_n), 32'h0);
        check("wr2_data", 32'(sram_data), 32'h3C);
        check("wr2_addr", 32'(sram_addr), 32'h00100);
        tick();
        check("wr3_we",   32'(sram_we_n), 32'h1);
        check("wr3_drv",  32'(dut.drive_en), 32'h1);
        check("wr3_data", 32'(sram_data), 32'h3C);
        check("wr3_ack",  32'(cack), 32'h0);
        tick();
        check("wr_ack",   32'(cack), 32'h1);
        check("wr_drv_off", 32'(dut.drive_en), 32'h0);
        check("wr_dout_untouched", 32'(cdout), 32'hA5);
        creq = 0; cwe = 0;
        tick();
        check("wr_ack_off", 32'(cack), 32'h0);
        check("wr_mem", 32'(mem[12'h100]), 32'h3C);

        // Read back the written location
        model_oe = 1'b1;
        creq = 1; cwe = 0; caddr = 19'h00100;
        tick(); tick(); tick();
        check("rb_ack",  32'(cack), 32'h1);
        check("rb_data", 32'(cdout), 32'h3C);
        creq = 0;
        tick();

        // Contention: all three raised together, all reads
        vreq = 1; vaddr = 19'h00200;
        creq = 1; cwe = 0; caddr = 19'h00300;
        lreq = 1; lwe = 0; laddr = 19'h00400;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("cont_vack_%0d", i), 32'(vack), 32'(i == 3));
            check($sformatf("cont_cack_%0d", i), 32'(cack), 32'(i == 6));
            check($sformatf("cont_lack_%0d", i), 32'(lack), 32'(i == 9));
            if (i == 3) vreq = 0;
            if (i == 6) creq = 0;
            if (i == 9) lreq = 0;
        end
        check("cont_vdata", 32'(vdata), 32'h11);
        check("cont_cdout", 32'(cdout), 32'h22);
        check("cont_ldout", 32'(ldout), 32'h33);
        check("cont_starve", 32'(dut.starve_cnt), 32'h0);

        // Starvation guard: CPU held, loader pending
        creq = 1; cwe = 0; caddr = 19'h00300;
        lreq = 1; lwe = 0; laddr = 19'h00400;
        for (int i = 1; i <= 22; i++) begin
            tick();
            check($sformatf("stv_cack_%0d", i), 32'(cack),
                  32'(i == 3 || i == 7 || i == 11 || i == 15 || i == 21));
            check($sformatf("stv_lack_%0d", i), 32'(lack), 32'(i == 18));
            if (i == 15) check("stv_cnt_limit", 32'(dut.starve_cnt), 32'h4);
            if (i == 18) begin
                check("stv_cnt_clear", 32'(dut.starve_cnt), 32'h0);
                lreq = 0;
            end
            if (i == 21) creq = 0;
        end
        check("stv_cnt_end", 32'(dut.starve_cnt), 32'h0);

        // Reset during WR2
        model_oe = 1'b0;
        creq = 1; cwe = 1; caddr = 19'h00500; cdin = 8'h5A;
        tick(); tick();
        check("rmw_wr2_we", 32'(sram_we_n), 32'h0);
        rst = 1'b1;
        #1;
        check("rmw_we_async",  32'(sram_we_n), 32'h1);
        check("rmw_drv_async", 32'(dut.drive_en), 32'h0);
        check("rmw_addr",      32'(sram_addr), 32'h0);
        tick();
        creq = 0; cwe = 0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rmw_cack_%0d", i), 32'(cack), 32'h0);
        end
        check("rmw_we_n",  32'(sram_we_n), 32'h1);
        check("rmw_douts", 32'({vdata, cdout, ldout}), 32'h0);
        check("rmw_addr2", 32'(sram_addr), 32'h0);
        check("rmw_cnt",   32'(dut.starve_cnt), 32'h0);
        check("rmw_mem",   32'(mem[12'h500]), 32'h00);

        // Held video request: no re-grant on the ack edge
        model_oe = 1'b1;
        vreq = 1; vaddr = 19'h00200;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("hold_vack_%0d", i), 32'(vack), 32'(i == 3 || i == 7));
            if (i == 3) check("hold_vdata", 32'(vdata), 32'h11);
            if (i == 7) vreq = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
